riscv_mul_issue: RTL and testbench

// Execute-stage issue/stall controller directly upstream of riscv_multiplier.

---
 rtl/riscv_mul_issue.sv | 131 +++++++++++++
 tb/tb_riscv_mul_issue.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/riscv_mul_issue.sv
// Issue/stall controller in front of riscv_multiplier: latches EX operands, holds them
// stable while the multiplier runs, stalls the pipeline and presents the product.
module riscv_mul_issue #(
   parameter int ZERO_BYPASS = 1,
   parameter int TIMEOUT     = 80,
   parameter int CNT_W       = 7
) (
   input  logic        i_riscv_mi_clk,
   input  logic        i_riscv_mi_rst,
   input  logic        i_riscv_mi_req,
   input  logic [3:0]  i_riscv_mi_mulctrl,
   input  logic [63:0] i_riscv_mi_rs1data,
   input  logic [63:0] i_riscv_mi_rs2data,
   input  logic        i_riscv_mi_flush,
   input  logic        i_riscv_mi_hold,
   output logic        o_riscv_mi_stall,
   output logic [63:0] o_riscv_mi_result,
   output logic        o_riscv_mi_resvalid,
   output logic        o_riscv_mi_err,
   output logic [3:0]  o_riscv_mi_mulctrl,
   output logic [63:0] o_riscv_mi_rs1data,
   output logic [63:0] o_riscv_mi_rs2data,
   input  logic [63:0] i_riscv_mi_mulproduct,
   input  logic        i_riscv_mi_mulvalid
);

   typedef enum logic [1:0] {IDLE, BUSY, DONE, DRAIN} state_t;

   state_t             state_q, state_d;
   logic [63:0]        rs1_q, rs2_q, result_q;
   logic [3:0]         ctrl_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               mul_req, zero_op, bypass, timeout;
   logic               start_op, cap_result;

   assign mul_req = i_riscv_mi_req &&
                    (i_riscv_mi_mulctrl inside {4'b1000, 4'b1100, 4'b1101, 4'b1110, 4'b1111});

   // MULW only consumes the low words, so only those decide whether the product is zero
   assign zero_op = (i_riscv_mi_mulctrl == 4'b1000) ?
                    ((i_riscv_mi_rs1data[31:0] == 32'd0) || (i_riscv_mi_rs2data[31:0] == 32'd0)) :
                    ((i_riscv_mi_rs1data == 64'd0) || (i_riscv_mi_rs2data == 64'd0));
   assign bypass  = (ZERO_BYPASS != 0) && zero_op;
   assign timeout = (cnt_q == CNT_W'(TIMEOUT - 1));

   assign o_riscv_mi_rs1data = rs1_q;
   assign o_riscv_mi_rs2data = rs2_q;

   always_comb begin
      state_d             = state_q;
      o_riscv_mi_stall    = 1'b0;
      o_riscv_mi_result   = 64'd0;
      o_riscv_mi_resvalid = 1'b0;
      o_riscv_mi_err      = 1'b0;
      o_riscv_mi_mulctrl  = 4'b0000;
      start_op            = 1'b0;
      cap_result          = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (mul_req && !i_riscv_mi_flush) begin
               if (bypass) begin
                  o_riscv_mi_resvalid = 1'b1;
               end else begin
                  o_riscv_mi_stall = 1'b1;
                  start_op         = 1'b1;
                  state_d          = BUSY;
               end
            end
         end
         BUSY: begin
            o_riscv_mi_mulctrl = ctrl_q;
            o_riscv_mi_stall   = 1'b1;
            // A flushed multiply may still be running, so drain it before reuse
            if (i_riscv_mi_flush) begin
               o_riscv_mi_stall = 1'b0;
               state_d          = i_riscv_mi_mulvalid ? IDLE : DRAIN;
            end else if (i_riscv_mi_mulvalid) begin
               cap_result = 1'b1;
               state_d    = DONE;
            end else if (timeout) begin
               o_riscv_mi_err = 1'b1;
               state_d        = IDLE;
            end
         end
         DONE: begin
            o_riscv_mi_result = result_q;
            if (i_riscv_mi_flush) begin
               state_d = IDLE;
            end else begin
               o_riscv_mi_resvalid = 1'b1;
               if (!i_riscv_mi_hold) state_d = IDLE;
            end
         end
         DRAIN: begin
            o_riscv_mi_stall = i_riscv_mi_req;
            if (i_riscv_mi_mulvalid) begin
               state_d = IDLE;
            end else if (timeout) begin
               o_riscv_mi_err = 1'b1;
               state_d        = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge i_riscv_mi_clk) begin
      if (i_riscv_mi_rst) begin
         state_q  <= IDLE;
         rs1_q    <= 64'd0;
         rs2_q    <= 64'd0;
         ctrl_q   <= 4'd0;
         result_q <= 64'd0;
         cnt_q    <= '0;
      end else begin
         state_q <= state_d;
         if (start_op) begin
            rs1_q  <= i_riscv_mi_rs1data;
            rs2_q  <= i_riscv_mi_rs2data;
            ctrl_q <= i_riscv_mi_mulctrl;
         end
         if (cap_result) result_q <= i_riscv_mi_mulproduct;
         // Watchdog restarts on every entry into BUSY or DRAIN
         if ((state_d == BUSY || state_d == DRAIN) && state_d != state_q)
            cnt_q <= '0;
         else if (state_q == BUSY || state_q == DRAIN)
            cnt_q <= cnt_q + 1'b1;
      end
   end

endmodule

// File: tb/tb_riscv_mul_issue.sv
// Self-checking bench for riscv_mul_issue: directed cases plus randomized multiplies
// against a behavioural model of the RISC-V multiply semantics.
module tb_riscv_mul_issue;

   localparam int TIMEOUT = 80;

   logic        clk = 1'b0;
   logic        rst;
   logic        req, flush, hold, mulvalid;
   logic [3:0]  mulctrl;
   logic [63:0] rs1, rs2, mulproduct;
   logic        stall, resvalid, err;
   logic [63:0] result, o_rs1, o_rs2;
   logic [3:0]  o_mulctrl;

   int n_tests = 0;
   int n_fail  = 0;

   riscv_mul_issue dut (
      .i_riscv_mi_clk        (clk),
      .i_riscv_mi_rst        (rst),
      .i_riscv_mi_req        (req),
      .i_riscv_mi_mulctrl    (mulctrl),
      .i_riscv_mi_rs1data    (rs1),
      .i_riscv_mi_rs2data    (rs2),
      .i_riscv_mi_flush      (flush),
      .i_riscv_mi_hold       (hold),
      .o_riscv_mi_stall      (stall),
      .o_riscv_mi_result     (result),
      .o_riscv_mi_resvalid   (resvalid),
      .o_riscv_mi_err        (err),
      .o_riscv_mi_mulctrl    (o_mulctrl),
      .o_riscv_mi_rs1data    (o_rs1),
      .o_riscv_mi_rs2data    (o_rs2),
      .i_riscv_mi_mulproduct (mulproduct),
      .i_riscv_mi_mulvalid   (mulvalid)
   );

   always #5 clk = ~clk;

   // RISC-V M-extension result, computed with wide arithmetic
   function automatic logic [63:0] ref_mul(input logic [3:0] c, input logic [63:0] a,
                                           input logic [63:0] b);
      logic [127:0] p;
      logic [31:0]  w;
      case (c)
         4'b1100: begin p = {64'd0, a} * {64'd0, b}; return p[63:0]; end
         4'b1101: begin p = {{64{a[63]}}, a} * {{64{b[63]}}, b}; return p[127:64]; end
         4'b1110: begin p = {64'd0, a} * {64'd0, b}; return p[127:64]; end
         4'b1111: begin p = {{64{a[63]}}, a} * {64'd0, b}; return p[127:64]; end
         default: begin w = a[31:0] * b[31:0]; return {{32{w[31]}}, w}; end
      endcase
   endfunction

   function automatic bit ref_zero(input logic [3:0] c, input logic [63:0] a,
                                   input logic [63:0] b);
      if (c == 4'b1000) return (a[31:0] == 32'd0) || (b[31:0] == 32'd0);
      return (a == 64'd0) || (b == 64'd0);
   endfunction

   task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_tests++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Drives one instruction from IDLE to completion; the multiplier answers after lat busy cycles.
   // Returns positioned just after a negedge with the DUT back in IDLE.
   task automatic apply_stimulus(input logic [3:0] c, input logic [63:0] a, input logic [63:0] b,
                                 input int lat, input int hold_n);
      logic [63:0] exp;
      exp = ref_zero(c, a, b) ? 64'd0 : ref_mul(c, a, b);
      req = 1'b1; mulctrl = c; rs1 = a; rs2 = b; flush = 1'b0; hold = 1'b0;
      mulvalid = 1'b0; mulproduct = {$urandom, $urandom};
      #1;
      if (ref_zero(c, a, b)) begin
         check_output("byp_resvalid", 64'(resvalid), 64'd1);
         check_output("byp_result", result, 64'd0);
         check_output("byp_stall", 64'(stall), 64'd0);
         check_output("byp_mulctrl", 64'(o_mulctrl), 64'd0);
         @(negedge clk);
         req = 1'b0;
         #1;
         check_output("byp_nostart", 64'(o_mulctrl), 64'd0);
         return;
      end
      check_output("idle_stall", 64'(stall), 64'd1);
      check_output("idle_mulctrl", 64'(o_mulctrl), 64'd0);
      check_output("idle_resvalid", 64'(resvalid), 64'd0);
      @(negedge clk);
      for (int k = 1; k <= lat; k++) begin
         mulvalid   = (k == lat);
         mulproduct = (k == lat) ? ref_mul(o_mulctrl, o_rs1, o_rs2) : {$urandom, $urandom};
         #1;
         check_output("busy_stall", 64'(stall), 64'd1);
         check_output("busy_mulctrl", 64'(o_mulctrl), 64'(c));
         check_output("busy_rs1", o_rs1, a);
         check_output("busy_rs2", o_rs2, b);
         check_output("busy_resvalid", 64'(resvalid), 64'd0);
         @(negedge clk);
      end
      mulvalid = 1'b0; mulproduct = {$urandom, $urandom}; req = 1'b0;
      for (int h = 0; h <= hold_n; h++) begin
         hold = (h < hold_n);
         #1;
         check_output("done_resvalid", 64'(resvalid), 64'd1);
         check_output("done_result", result, exp);
         check_output("done_stall", 64'(stall), 64'd0);
         check_output("done_mulctrl", 64'(o_mulctrl), 64'd0);
         @(negedge clk);
      end
      hold = 1'b0;
      #1;
      check_output("after_resvalid", 64'(resvalid), 64'd0);
      check_output("after_stall", 64'(stall), 64'd0);
   endtask

   initial begin
      logic [3:0]  codes [5] = '{4'b1100, 4'b1101, 4'b1110, 4'b1111, 4'b1000};
      logic [3:0]  c;
      logic [63:0] a, b;

      rst = 1'b1; req = 1'b0; flush = 1'b0; hold = 1'b0; mulvalid = 1'b0;
      mulctrl = 4'd0; rs1 = 64'd0; rs2 = 64'd0; mulproduct = 64'd0;
      repeat (3) @(negedge clk);
      #1;
      check_output("rst_stall", 64'(stall), 64'd0);
      check_output("rst_resvalid", 64'(resvalid), 64'd0);
      check_output("rst_result", result, 64'd0);
      check_output("rst_err", 64'(err), 64'd0);
      check_output("rst_mulctrl", 64'(o_mulctrl), 64'd0);
      check_output("rst_rs1", o_rs1, 64'd0);
      check_output("rst_rs2", o_rs2, 64'd0);
      @(negedge clk);
      rst = 1'b0;

      apply_stimulus(4'b1100, 64'd3, 64'd5, 5, 0);
      apply_stimulus(4'b1110, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 12, 0);
      apply_stimulus(4'b1000, 64'h7FFF_FFFF, 64'd2, 66, 0);
      apply_stimulus(4'b1100, 64'd1234, 64'd0, 1, 0);
      apply_stimulus(4'b1000, 64'hABCD_0000_0000, 64'd5, 1, 0);
      apply_stimulus(4'b1101, 64'h8000_0000_0000_0001, 64'd3, 8, 3);

      // Non-multiply code and a flushed request must both leave the block idle
      req = 1'b1; mulctrl = 4'b0101; rs1 = 64'd9; rs2 = 64'd9;
      #1;
      check_output("nonmul_stall", 64'(stall), 64'd0);
      check_output("nonmul_resvalid", 64'(resvalid), 64'd0);
      @(negedge clk);
      mulctrl = 4'b1100; flush = 1'b1;
      #1;
      check_output("idleflush_stall", 64'(stall), 64'd0);
      @(negedge clk);
      flush = 1'b0; req = 1'b0;
      #1;
      check_output("idleflush_mulctrl", 64'(o_mulctrl), 64'd0);
      @(negedge clk);

      // Flush ten cycles into BUSY, with the next MUL waiting through DRAIN
      req = 1'b1; mulctrl = 4'b1100; rs1 = 64'd11; rs2 = 64'd13;
      @(negedge clk);
      repeat (10) @(negedge clk);
      flush = 1'b1;
      #1;
      check_output("flush_stall", 64'(stall), 64'd0);
      check_output("flush_resvalid", 64'(resvalid), 64'd0);
      @(negedge clk);
      flush = 1'b0; rs1 = 64'd7; rs2 = 64'd6;
      for (int d = 1; d <= 5; d++) begin
         mulvalid = (d == 5); mulproduct = 64'd143;
         #1;
         check_output("drain_stall", 64'(stall), 64'd1);
         check_output("drain_mulctrl", 64'(o_mulctrl), 64'd0);
         check_output("drain_resvalid", 64'(resvalid), 64'd0);
         check_output("drain_rs1", o_rs1, 64'd11);
         @(negedge clk);
      end
      mulvalid = 1'b0;
      apply_stimulus(4'b1100, 64'd7, 64'd6, 20, 0);

      // Multiplier never answers: watchdog fires on the TIMEOUT-th busy cycle
      req = 1'b1; mulctrl = 4'b1111; rs1 = 64'd21; rs2 = 64'd22;
      @(negedge clk);
      for (int k = 1; k <= TIMEOUT; k++) begin
         if (k == TIMEOUT) req = 1'b0;
         #1;
         if (k == TIMEOUT) begin
            check_output("wd_err", 64'(err), 64'd1);
            check_output("wd_resvalid", 64'(resvalid), 64'd0);
         end else if (k == 1 || k == TIMEOUT - 1) begin
            check_output("wd_early_err", 64'(err), 64'd0);
         end
         @(negedge clk);
      end
      #1;
      check_output("wd_err_pulse", 64'(err), 64'd0);
      check_output("wd_idle_mulctrl", 64'(o_mulctrl), 64'd0);
      check_output("wd_idle_resvalid", 64'(resvalid), 64'd0);
      @(negedge clk);

      for (int i = 0; i < 25; i++) begin
         c = codes[$urandom_range(0, 4)];
         a = {$urandom, $urandom};
         b = {$urandom, $urandom};
         if ($urandom_range(0, 5) == 0) a = 64'd0;
         if ($urandom_range(0, 7) == 0) b[31:0] = 32'd0;
         apply_stimulus(c, a, b, $urandom_range(1, 70), $urandom_range(0, 3));
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
